// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg : shared PS/2 types and command constants              rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      START     = 3'd2,
      BITS      = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } tx_state_t;

   localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
   localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ---------------------------------------------------------------------------
// ps2_line_filter : 2-FF synchronizer, stability filter, fall detect  rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall
);

   localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

   logic [1:0]       sync;
   logic [CNT_W-1:0] run;

   // A new level is accepted only after FILTER_LEN consecutive differing samples.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= 2'b11;
         level <= 1'b1;
         fall  <= 1'b0;
         run   <= '0;
      end else begin
         sync <= {sync[0], line_in};
         fall <= 1'b0;
         if (sync[1] == level) begin
            run <= '0;
         end else if (run == CNT_W'(FILTER_LEN - 1)) begin
            level <= sync[1];
            fall  <= level;
            run   <= '0;
         end else begin
            run <= run + 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/ps2_tx.sv
// ---------------------------------------------------------------------------
// ps2_tx : host-to-device PS/2 command transmitter (open-drain)    rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ps2_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int SETUP_CYCLES   = 200,
   parameter int FILTER_LEN     = 8,
   parameter int START_TIMEOUT  = 1500000,
   parameter int XFER_TIMEOUT   = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tbr,
   input  logic [7:0] tx_data,
   inout  wire        ps2_clk,
   inout  wire        ps2_data,
   output logic       busy,
   output logic       sent,
   output logic       err
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TMR_MAX = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   tx_state_t        state, state_nxt;
   logic [9:0]       frame, frame_nxt;
   logic [3:0]       bitcnt, bitcnt_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic             clk_oe, clk_oe_nxt;
   logic             data_oe, data_oe_nxt;
   logic             clk_level, clk_fall;
   logic [1:0]       data_sync;

   assign ps2_clk  = clk_oe  ? 1'b0 : 1'bz;
   assign ps2_data = data_oe ? 1'b0 : 1'bz;
   assign busy     = (state != IDLE);

   ps2_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk     (clk),
      .rst     (rst),
      .line_in (ps2_clk),
      .level   (clk_level),
      .fall    (clk_fall)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         frame     <= '0;
         bitcnt    <= '0;
         cnt       <= '0;
         timer     <= '0;
         clk_oe    <= 1'b0;
         data_oe   <= 1'b0;
         data_sync <= 2'b11;
      end else begin
         state     <= state_nxt;
         frame     <= frame_nxt;
         bitcnt    <= bitcnt_nxt;
         cnt       <= cnt_nxt;
         timer     <= timer_nxt;
         clk_oe    <= clk_oe_nxt;
         data_oe   <= data_oe_nxt;
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   always_comb begin
      state_nxt   = state;
      frame_nxt   = frame;
      bitcnt_nxt  = bitcnt;
      cnt_nxt     = cnt;
      timer_nxt   = timer;
      clk_oe_nxt  = clk_oe;
      data_oe_nxt = data_oe;
      sent        = 1'b0;
      err         = 1'b0;

      case (state)
         IDLE: begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            if (tbr) begin
               frame_nxt  = {1'b1, odd_parity(tx_data), tx_data};
               cnt_nxt    = CNT_W'(INHIBIT_CYCLES - 1);
               clk_oe_nxt = 1'b1;
               state_nxt  = INHIBIT;
            end
         end

         INHIBIT: begin
            if (cnt == '0) begin
               cnt_nxt     = CNT_W'(SETUP_CYCLES - 1);
               data_oe_nxt = 1'b1;
               state_nxt   = START;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end

         START: begin
            if (cnt == '0) begin
               clk_oe_nxt = 1'b0;
               bitcnt_nxt = '0;
               timer_nxt  = TMR_W'(START_TIMEOUT);
               state_nxt  = BITS;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end

         BITS, ACK, WAIT_IDLE: begin
            timer_nxt = timer - 1'b1;
            if (timer == '0) begin
               timer_nxt   = '0;
               clk_oe_nxt  = 1'b0;
               data_oe_nxt = 1'b0;
               err         = 1'b1;
               state_nxt   = IDLE;
            end else if (state == BITS) begin
               // Frame shifts out LSB first; the stop bit (1) releases data.
               if (clk_fall) begin
                  data_oe_nxt = ~frame[0];
                  frame_nxt   = {1'b0, frame[9:1]};
                  bitcnt_nxt  = bitcnt + 1'b1;
                  if (bitcnt == 4'd0) timer_nxt = TMR_W'(XFER_TIMEOUT);
                  if (bitcnt == 4'd9) state_nxt = ACK;
               end
            end else if (state == ACK) begin
               data_oe_nxt = 1'b0;
               if (clk_fall) begin
                  if (data_sync[1]) begin
                     err       = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = WAIT_IDLE;
                  end
               end
            end else if (clk_level && data_sync[1]) begin
               sent      = 1'b1;
               state_nxt = IDLE;
            end
         end

         default: begin
            clk_oe_nxt  = 1'b0;
            data_oe_nxt = 1'b0;
            state_nxt   = IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_ps2_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_tx : PS/2 device model and checker for ps2_tx             rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ps2_tx;

   localparam int HALF   = 40;
   localparam int INH    = 40;
   localparam int SETUP  = 4;
   localparam int START_TO = 2000;
   localparam int XFER_TO  = 4000;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tbr = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       busy, sent, err;
   logic       dev_clk_low  = 1'b0;
   logic       dev_data_low = 1'b0;
   wire        ps2_clk;
   wire        ps2_data;

   int checks = 0;
   int errors = 0;
   int sent_cnt = 0;
   int err_cnt = 0;
   int busy_bad = 0;
   int width_bad = 0;
   bit pulse_d = 1'b0;

   pullup (ps2_clk);
   pullup (ps2_data);
   assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
   assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

   always #5 clk = ~clk;

   ps2_tx #(
      .INHIBIT_CYCLES (INH),
      .SETUP_CYCLES   (SETUP),
      .FILTER_LEN     (8),
      .START_TIMEOUT  (START_TO),
      .XFER_TIMEOUT   (XFER_TO)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .tbr      (tbr),
      .tx_data  (tx_data),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .busy     (busy),
      .sent     (sent),
      .err      (err)
   );

   // Pulse bookkeeping: counts, width, exclusivity, busy after completion.
   always @(negedge clk) begin
      if (sent === 1'b1) sent_cnt++;
      if (err === 1'b1) err_cnt++;
      if (sent === 1'b1 && err === 1'b1) width_bad++;
      if (pulse_d && (sent === 1'b1 || err === 1'b1)) width_bad++;
      if (pulse_d && busy !== 1'b0) busy_bad++;
      pulse_d = (sent === 1'b1) || (err === 1'b1);
   end

   initial begin
      #600000;
      $display("FAIL watchdog: observed no finish expected finish before time limit");
      $fatal(1);
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_tx(input logic [7:0] b);
      tx_data = b;
      tbr     = 1'b1;
      @(negedge clk);
      tbr     = 1'b0;
   endtask

   // Counts cycles the host holds clk low and records data just before release.
   task automatic wait_release(output int low, output logic d_last);
      int n;
      n = 0;
      low = 0;
      d_last = 1'b1;
      while (ps2_clk !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      while (ps2_clk === 1'b0 && low < 1000) begin
         d_last = ps2_data;
         @(negedge clk);
         low++;
      end
   endtask

   // One device clock: low half, sample data at the rising edge, high half.
   task automatic dev_pulse(input bit inject, output logic s);
      dev_clk_low = 1'b1;
      for (int c = 0; c < HALF; c++) begin
         if (inject && c == 0) begin
            tbr     = 1'b1;
            tx_data = 8'h00;
         end else begin
            tbr = 1'b0;
         end
         @(negedge clk);
      end
      tbr = 1'b0;
      s = ps2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
   endtask

   task automatic run_frame(input logic [7:0] b, input bit nack, input bit inject);
      logic [10:0] got;
      logic        s, d_last;
      logic        exp_par;
      int          low, s0, e0, n;
      s0 = sent_cnt;
      e0 = err_cnt;
      got = '0;
      exp_par = ($countones(b) % 2 == 0);
      start_tx(b);
      wait_release(low, d_last);
      check("inhibit_len", int'(low >= INH && low < 100), 1);
      check("start_bit", int'(d_last), 0);
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         dev_pulse(inject && i == 3, s);
         got[i] = s;
      end
      dev_data_low = !nack;
      dev_pulse(1'b0, s);
      dev_data_low = 1'b0;
      n = 0;
      while (sent_cnt == s0 && err_cnt == e0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("data_byte", int'(got[7:0]), int'(b));
      check("parity", int'(got[8]), int'(exp_par));
      check("stop_bit", int'(got[9]), 1);
      check("sent_pulses", sent_cnt - s0, nack ? 0 : 1);
      check("err_pulses", err_cnt - e0, nack ? 1 : 0);
      check("idle_state", int'({busy, ps2_clk, ps2_data}), 3);
      check("pulse_shape", busy_bad + width_bad, 0);
   endtask

   initial begin
      logic s, d_last;
      int   low, cyc, s0, e0;

      repeat (4) @(negedge clk);
      check("reset_out", int'({busy, sent, err, ps2_clk, ps2_data}), 3);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      run_frame(8'hFF, 1'b0, 1'b0);
      run_frame(8'hF4, 1'b0, 1'b0);
      run_frame(8'hED, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) run_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);

      run_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);

      // Device never clocks: error START_TO cycles after clk release.
      e0 = err_cnt;
      start_tx(8'hF4);
      wait_release(low, d_last);
      cyc = 0;
      while (err !== 1'b1 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
      end
      check("start_timeout", cyc, START_TO);
      @(negedge clk);
      check("timeout_release", int'({busy, ps2_clk, ps2_data}), 3);
      repeat (3) @(negedge clk);
      check("timeout_err_cnt", err_cnt - e0, 1);

      run_frame(8'hF4, 1'b0, 1'b1);

      // Asynchronous reset in the middle of the data bits.
      s0 = sent_cnt;
      e0 = err_cnt;
      start_tx(8'h00);
      wait_release(low, d_last);
      repeat (HALF) @(negedge clk);
      for (int i = 0; i < 4; i++) dev_pulse(1'b0, s);
      check("pre_rst_drive", int'({busy, ps2_data}), 2);
      #2 rst = 1'b0;
      #1;
      check("rst_release", int'({busy, sent, err, ps2_clk, ps2_data}), 3);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("rst_no_pulse", (sent_cnt - s0) + (err_cnt - e0), 0);

      run_frame(8'hFF, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter that sends one command byte (e.g. 0xFF reset, 0xF4 enable reporting) to a mouse or keyboard over the shared open-drain clock/data pair. It is the transmit companion to ps2_rx. It closes the tbr/tx_data/sent handshake used by the mouse controller FSM in its SEND_RST and SEND_VAL states. While busy it owns the bus, and the controller ignores ps2_rx during that time.

Parameters:
INHIBIT_CYCLES, 10000, clk cycles ps2_clk is held low before the start bit (100 us at 100 MHz)
SETUP_CYCLES, 200, cycles data is held low with clk still low before clk is released
FILTER_LEN, 8, consecutive identical synchronized samples required to accept a ps2_clk level change
START_TIMEOUT, 1500000, max cycles from clk release to the first device falling edge (15 ms)
XFER_TIMEOUT, 200000, max cycles from the first falling edge to ACK completion (2 ms)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset)
tbr  input  1  transmit request; sampled only in IDLE
tx_data  input  8  byte to send; captured when tbr is accepted
ps2_clk  inout  1  PS/2 clock, open-drain (driven 0 or z)
ps2_data  inout  1  PS/2 data, open-drain (driven 0 or z)
busy  output  1  high in every state except IDLE
sent  output  1  one-cycle pulse: byte acknowledged and bus returned to idle
err  output  1  one-cycle pulse: NACK or timeout; block returns to IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, clk_oe=0, data_oe=0 (both lines released immediately), busy=0, sent=0, err=0, all counters and the shift register cleared.
- Line pins: ps2_clk = clk_oe ? 0 : z. ps2_data = data_oe ? 0 : z. No output ever drives 1.
- ps2_clk input path: 2-FF synchronizer, then FILTER_LEN-sample stable filter. fall = one-cycle pulse on a filtered 1->0 transition. ps2_data uses a 2-FF synchronizer only.
- Frame: shift register {stop=1, parity, tx_data[7:0]}. Sent LSB first. Parity is odd: parity = ~^tx_data.
- IDLE: busy=0. If tbr=1: latch the frame, load counter, go to INHIBIT. busy rises the next cycle.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES, then go to START.
- START: clk_oe=1, data_oe=1 (start bit 0) for SETUP_CYCLES. Then clk_oe=0, bitcnt=0, timer=START_TIMEOUT, go to BITS.
- BITS: on each fall, data_oe = ~frame[bitcnt] and bitcnt++.
  - Falls 1..8 present D0..D7, fall 9 presents parity, fall 10 presents stop (data released).
  - After fall 10, go to ACK.
  - On the first fall, timer reloads with XFER_TIMEOUT.
- ACK: data_oe=0. On the next fall, sample ps2_data.
  - 0 = ACK: go to WAIT_IDLE.
  - 1 = NACK: pulse err, go to IDLE.
- WAIT_IDLE: wait until filtered ps2_clk=1 and synced ps2_data=1, then pulse sent and go to IDLE. The XFER timer still applies.
- Timeout: the timer decrements in BITS, ACK and WAIT_IDLE. At 0: release both lines, pulse err, go to IDLE.
- sent and err are mutually exclusive and each is exactly one cycle wide. They are asserted in the same cycle the FSM enters IDLE, so busy falls on the following cycle.
- tbr while busy=1 is ignored, not queued. tx_data changes after acceptance do not affect the frame in flight.
- If tbr is held high across completion, a new transfer starts on the first IDLE cycle.
- A fall during INHIBIT or START (device contention) is ignored. Clk is held low.
- Async reset mid-frame: lines are released within the same cycle and no sent/err pulse is produced. The device times out on its own.
- Latency: sent occurs at INHIBIT_CYCLES + SETUP_CYCLES + device timing + 3 (sync) + FILTER_LEN cycles after tbr, minimum.

Decomposition:
- Package ps2_pkg holds:
  - the tx state enum (IDLE, INHIBIT, START, BITS, ACK, WAIT_IDLE);
  - command constants PS2_CMD_RESET=8'hFF, PS2_CMD_ENABLE=8'hF4, PS2_CMD_SET_LEDS=8'hED;
  - response constant PS2_RESP_ACK=8'hFA.
- Sub-module ps2_line_filter (synchronizer, glitch filter, fall detect), parameterized by FILTER_LEN. ps2_rx can share it later.
- The FSM, timers and shift register stay in ps2_tx.

Test Plan:
- Bench setup: reduced parameters (INHIBIT_CYCLES=40, SETUP_CYCLES=4, START_TIMEOUT=2000, XFER_TIMEOUT=4000) and a device model clocking at 40-cycle half-periods.
- tbr with tx_data=0xFF -> clk low >=40 cycles, data low before clk release. Device samples bits 1,1,1,1,1,1,1,1, parity 1, stop 1. Device ACKs, then exactly one sent pulse, err=0.
- tx_data=0xF4 -> device captures data 0xF4, parity 0. sent pulse. Repeat with 0xED -> parity 1.
- Device drives data high at ACK (NACK) -> one err pulse, no sent, busy=0 the next cycle, both lines z.
- Device never clocks -> err exactly START_TIMEOUT cycles after clk release. Lines z.
- tbr pulsed again mid-frame with tx_data=0x00 -> ignored. Device still receives the original 0xF4, one sent pulse total.
- rst=0 asserted during bit 4 -> ps2_clk/ps2_data z and busy=0 in the same cycle, no sent/err. After release, a new 0xFF transfer completes normally.
